// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the load/store unit.
// Holds the RV64 funct3 encodings for memory accesses, the access-size
// decode, the illegal-funct3 check and the load/store FSM state type.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_RESP,
    S_ERR
  } lsu_state_t;

  // Access size in bytes: 1, 2, 4 or 8.
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

  // 111 is never a memory access; unsigned word (110) has no store form.
  function automatic logic funct3_illegal(input logic write, input logic [2:0] funct3);
    return (funct3 == 3'b111) || (write && funct3 == F3_WU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit (purely combinational).
// Ports:
//   funct3  in   access type (size in [1:0], unsigned flag in [2])
//   offset  in   byte offset of the access within the doubleword
//   base    in   doubleword read from memory, merged with store data
//   wdata   in   right-justified store data
//   line    in   doubleword holding the load data
//   merged  out  base with the addressed bytes replaced by wdata
//   ldata   out  addressed field of line, shifted down and extended
module lsu_align
  import riscv_mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3,
  input  logic [2:0]      offset,
  input  logic [XLEN-1:0] base,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] line,
  output logic [XLEN-1:0] merged,
  output logic [XLEN-1:0] ldata
);

  localparam int NB = XLEN / 8;

  logic [3:0]      size;
  logic [XLEN-1:0] shifted;

  assign size    = size_bytes(funct3);
  assign shifted = line >> {offset, 3'b000};

  // Little-endian merge: byte i of the line takes byte (i - offset) of wdata
  // when it falls inside the addressed field, otherwise keeps the old byte.
  always_comb begin
    merged = base;
    for (int i = 0; i < NB; i++) begin
      if (i >= int'(offset) && i < int'(offset) + int'(size)) begin
        merged[8*i +: 8] = wdata[8*(i - int'(offset)) +: 8];
      end
    end
  end

  // funct3[2] selects zero extension; doubleword needs no extension.
  always_comb begin
    ldata = shifted;
    case (funct3[1:0])
      2'b00:   ldata = funct3[2] ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                 : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      2'b01:   ldata = funct3[2] ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                 : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      2'b10:   ldata = funct3[2] ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                 : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      default: ldata = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store unit in front of a doubleword-wide data memory.
// Each access becomes single-operation memory cycles; sub-doubleword stores
// are read-modify-write. Misaligned, out-of-range and illegal accesses are
// answered with resp_err without strobing the memory.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only when idle)
//   req_write, req_funct3       store flag and RV funct3
//   req_addr, req_wdata         byte address, right-justified store data
//   resp_valid                  one-cycle completion pulse
//   resp_rdata, resp_err        extended load data, error flag
//   mem_read, mem_write         memory strobes (never both high)
//   mem_addr, mem_wdata         doubleword index and write data
//   mem_rdata                   memory read data, valid cycle after mem_read
module load_store_unit
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int XLEN  = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t      state_q, state_d;
  logic            write_q;
  logic [2:0]      funct3_q;
  logic [2:0]      offset_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] line_q;
  logic            mem_read_q;
  logic            mem_write_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wdata_q;

  logic            accept;
  logic [3:0]      req_size;
  logic            req_misaligned;
  logic            req_out_of_range;
  logic            req_err;
  logic [XLEN-1:0] merged;
  logic [XLEN-1:0] ldata;

  assign accept           = req_valid && (state_q == S_IDLE);
  assign req_size         = size_bytes(req_funct3);
  assign req_misaligned   = (req_addr[2:0] & 3'(req_size - 4'd1)) != 3'd0;
  assign req_out_of_range = (req_addr >> 3) >= XLEN'(DEPTH);
  assign req_err          = req_misaligned || req_out_of_range ||
                            funct3_illegal(req_write, req_funct3);

  // The RMW merge uses mem_rdata directly in RD_WAIT so the write data is
  // ready in the same cycle the line is captured.
  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3 (funct3_q),
    .offset (offset_q),
    .base   (mem_rdata),
    .wdata  (wdata_q),
    .line   (line_q),
    .merged (merged),
    .ldata  (ldata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                                  state_d = S_ERR;
          else if (req_write && req_funct3[1:0] == 2'b11) state_d = S_WR;
          else                                          state_d = S_RD;
        end
      end
      S_RD:      state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = write_q ? S_WR : S_RESP;
      S_WR:      state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      funct3_q    <= 3'd0;
      offset_q    <= 3'd0;
      wdata_q     <= '0;
      line_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      // Strobes are registered from the next state, so each is high for
      // exactly the one cycle spent in RD or WR.
      mem_read_q  <= (state_d == S_RD);
      mem_write_q <= (state_d == S_WR);
      if (accept) begin
        write_q    <= req_write;
        funct3_q   <= req_funct3;
        offset_q   <= req_addr[2:0];
        wdata_q    <= req_wdata;
        mem_addr_q <= req_addr >> 3;
      end
      if (state_q == S_RD_WAIT) begin
        line_q <= mem_rdata;
      end
      if (state_d == S_WR) begin
        mem_wdata_q <= (state_q == S_IDLE) ? req_wdata : merged;
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP) || (state_q == S_ERR);
  assign resp_err   = (state_q == S_ERR);
  assign resp_rdata = (state_q == S_RESP && !write_q) ? ldata : '0;

  // A reset arriving while a strobe is up cancels it in that same cycle,
  // so an interrupted RMW never reaches memory.
  assign mem_read   = mem_read_q && !reset;
  assign mem_write  = mem_write_q && !reset;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int DEPTH = 32;
  localparam int XLEN  = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic            mem_read;
  logic            mem_write;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  load_store_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    longint      acc;
  } exp_t;

  exp_t        expq[$];
  logic [63:0] mem     [DEPTH];
  logic [63:0] ref_mem [DEPTH];
  logic        preload;
  longint      cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          resp_seen = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [63:0] cur_idx = '0;
  logic [63:0] last_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Data memory: one-cycle read latency, write on posedge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
    end else if (mem_write && mem_addr < 64'(DEPTH)) begin
      mem[mem_addr[4:0]] <= mem_wdata;
    end
    if (mem_read) mem_rdata <= mem[mem_addr[4:0]];
  end

  // Reference model: applies the access to ref_mem and predicts the response.
  task automatic model(input logic w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, output exp_t e);
    int          sz;
    int          off;
    logic [63:0] v;
    logic [63:0] idx;
    logic [63:0] mask;
    sz  = 1 << f3[1:0];
    off = int'(a[2:0]);
    idx = a >> 3;
    e.rdata = '0; e.err = 1'b0; e.nrd = 0; e.nwr = 0; e.lat = 0; e.acc = 0;
    if (f3 == 3'b111 || (w && f3 == 3'b110) || (a % 64'(sz)) != 0 || idx >= 64'(DEPTH)) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (w) begin
      e.nwr = 1;
      if (sz == 8) begin
        ref_mem[idx[4:0]] = wd;
        e.lat = 2;
      end else begin
        for (int k = 0; k < sz; k++) ref_mem[idx[4:0]][8*(off+k) +: 8] = wd[8*k +: 8];
        e.lat = 4;
        e.nrd = 1;
      end
    end else begin
      e.nrd = 1;
      e.lat = 3;
      v = ref_mem[idx[4:0]] >> (8 * off);
      if (sz < 8) begin
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v = v & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
      end
      e.rdata = v;
    end
  endtask

  // Compare process: strobes every cycle, responses against the model queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_read || mem_write) begin
        chk("strobe_overlap", {63'd0, mem_read && mem_write}, 64'd0);
        chk("strobe_addr", mem_addr, cur_idx);
        if (mem_read)  rd_cnt++;
        if (mem_write) wr_cnt++;
      end
      if (resp_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_resp", {63'd0, resp_valid}, 64'd0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_latency", 64'(cyc - e.acc), 64'(e.lat));
          chk("mem_read_count", 64'(rd_cnt), 64'(e.nrd));
          chk("mem_write_count", 64'(wr_cnt), 64'(e.nwr));
        end
        last_rdata = resp_rdata;
        resp_seen++;
      end
    end
  end

  task automatic do_access(input logic w, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] wd);
    exp_t e;
    int   n;
    int   target;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("ready_timeout", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b0;
      return;
    end
    model(w, f3, a, wd, e);
    e.acc   = cyc;
    rd_cnt  = 0;
    wr_cnt  = 0;
    cur_idx = a >> 3;
    target  = resp_seen + 1;
    expq.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (resp_seen < target && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (resp_seen < target) chk("resp_timeout", 64'(resp_seen), 64'(target));
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = {32'hA5A50000 | 32'(i), 32'h5A5A0000 | 32'(i)};
    ref_mem[1] = 64'h00000000F0E0D0C0;
    ref_mem[2] = 64'h8877665544332211;
    preload = 1'b1;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_mem_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    preload = 1'b0;
    reset = 1'b0;

    // Loads with sign and zero extension
    do_access(1'b0, 3'b000, 64'h13, 64'd0);
    chk("lit_lb_13", last_rdata, 64'h0000000000000044);
    do_access(1'b0, 3'b010, 64'h0C, 64'd0);
    chk("lit_lw_0c", last_rdata, 64'h0);
    do_access(1'b0, 3'b001, 64'h08, 64'd0);
    chk("lit_lh_08", last_rdata, 64'hFFFFFFFFFFFFD0C0);
    do_access(1'b0, 3'b101, 64'h08, 64'd0);
    chk("lit_lhu_08", last_rdata, 64'h000000000000D0C0);

    // RMW byte store keeps the other lanes
    do_access(1'b1, 3'b000, 64'h15, 64'hAB);
    chk("lit_mem2_after_sb", mem[2], 64'h8877AB5544332211);
    do_access(1'b0, 3'b011, 64'h10, 64'd0);
    chk("lit_ld_10", last_rdata, 64'h8877AB5544332211);
    do_access(1'b0, 3'b000, 64'h17, 64'd0);
    chk("lit_lb_17", last_rdata, 64'hFFFFFFFFFFFFFF88);

    // Doubleword store bypasses the read
    do_access(1'b1, 3'b011, 64'h20, 64'hDEADBEEFCAFEF00D);
    chk("lit_mem4_after_sd", mem[4], 64'hDEADBEEFCAFEF00D);
    do_access(1'b0, 3'b110, 64'h24, 64'd0);
    chk("lit_lwu_24", last_rdata, 64'h00000000DEADBEEF);
    do_access(1'b0, 3'b010, 64'h24, 64'd0);
    chk("lit_lw_24", last_rdata, 64'hFFFFFFFFDEADBEEF);

    // Errors
    do_access(1'b0, 3'b010, 64'h06, 64'd0);
    do_access(1'b0, 3'b011, 64'h100, 64'd0);
    do_access(1'b1, 3'b110, 64'h08, 64'h55);
    do_access(1'b0, 3'b111, 64'h08, 64'd0);
    do_access(1'b0, 3'b001, 64'h07, 64'd0);
    do_access(1'b1, 3'b011, 64'h24, 64'h1);
    do_access(1'b1, 3'b000, 64'h8000000000000010, 64'h1);

    // Further stores/loads, including the last valid doubleword
    do_access(1'b1, 3'b001, 64'h1A, 64'hFFFF1234);
    do_access(1'b1, 3'b010, 64'h1C, 64'h89ABCDEF);
    do_access(1'b0, 3'b011, 64'h18, 64'd0);
    do_access(1'b1, 3'b000, 64'hFF, 64'h7E);
    do_access(1'b0, 3'b011, 64'hF8, 64'd0);
    do_access(1'b0, 3'b100, 64'hFF, 64'd0);
    chk("lit_lbu_ff", last_rdata, 64'h000000000000007E);

    // Reset while the write of an SH RMW is on the bus
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001;
    req_addr = 64'h08; req_wdata = 64'h1234;
    rd_cnt = 0; wr_cnt = 0; cur_idx = 64'd1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (!mem_write && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reached_wr", {63'd0, mem_write}, 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_wr_suppressed", {63'd0, mem_write}, 64'd0);
    chk("rst_wr_no_resp", {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    chk("rst2_ready", {63'd0, req_ready}, 64'd1);
    chk("rst2_resp", {61'd0, resp_valid, resp_err, |resp_rdata}, 64'd0);
    chk("rst2_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    chk("rst2_mem_addr", mem_addr, 64'd0);
    chk("rst2_mem_wdata", mem_wdata, 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem1_unchanged", mem[1], 64'h00000000F0E0D0C0);
    do_access(1'b0, 3'b011, 64'h08, 64'd0);
    chk("lit_ld_08_after_rst", last_rdata, 64'h00000000F0E0D0C0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
